// File: rtl/rv_iopmp_entry_fetch_arbiter.sv
// rv_iopmp_entry_fetch_arbiter
// Shares the single-port IOPMP entry BRAM between the configuration path and
// the entry-scan engine. Holds the round-robin arbiter, the scan sequencer and
// a 2-deep entry buffer with valid/ready backpressure toward the checker.

module rv_iopmp_entry_fetch_arbiter #(
  parameter  int unsigned NUMBER_ENTRIES = 8,
  parameter  int unsigned BRAM_DWIDTH    = 128,
  localparam int unsigned AW             = $clog2(NUMBER_ENTRIES)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // configuration path
  input  logic                   cfg_req_i,
  input  logic                   cfg_we_i,
  input  logic [AW-1:0]          cfg_addr_i,
  input  logic [BRAM_DWIDTH-1:0] cfg_din_i,
  output logic                   cfg_gnt_o,
  output logic                   cfg_rvalid_o,
  output logic [BRAM_DWIDTH-1:0] cfg_rdata_o,
  // scan control
  input  logic                   scan_start_i,
  input  logic [AW-1:0]          scan_first_i,
  input  logic [AW-1:0]          scan_last_i,
  input  logic                   scan_abort_i,
  output logic                   scan_ready_o,
  // entry stream
  output logic                   entry_valid_o,
  input  logic                   entry_ready_i,
  output logic [BRAM_DWIDTH-1:0] entry_data_o,
  output logic [AW-1:0]          entry_idx_o,
  output logic                   scan_done_o,
  // BRAM port
  output logic                   we_bram_o,
  output logic                   en_bram_o,
  output logic [AW-1:0]          addr_bram_o,
  output logic [BRAM_DWIDTH-1:0] din_bram_o,
  input  logic [BRAM_DWIDTH-1:0] dout_bram_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                 state_q;
  logic [AW-1:0]          next_addr_q;
  logic [AW-1:0]          last_q;
  logic                   scan_done_q;
  logic                   rr_scan_q;      // 1: scan wins the next contended cycle
  logic                   inflight_q;
  logic [AW-1:0]          inflight_idx_q;
  logic                   cfg_rvalid_q;
  logic [1:0]             count_q;
  logic [BRAM_DWIDTH-1:0] head_data_q;
  logic [AW-1:0]          head_idx_q;
  logic [BRAM_DWIDTH-1:0] tail_data_q;
  logic [AW-1:0]          tail_idx_q;

  logic       aborting;
  logic       pop;
  logic       push;
  logic [2:0] occ;
  logic       scan_elig;
  logic       cfg_gnt;
  logic       scan_gnt;
  logic       drain_empty;

  // Arbitration: scan may issue only if the read still fits the 2-deep buffer.
  always_comb begin
    aborting    = scan_abort_i && (state_q != IDLE);
    pop         = (count_q != 2'd0) && entry_ready_i;
    push        = inflight_q && !aborting;
    occ         = 3'(count_q) + 3'(inflight_q);
    scan_elig   = (state_q == FETCH) && !aborting && (occ < (3'd2 + 3'(pop)));
    cfg_gnt     = cfg_req_i && (!scan_elig || !rr_scan_q);
    scan_gnt    = scan_elig && !cfg_gnt;
    drain_empty = !inflight_q &&
                  ((count_q == 2'd0) || ((count_q == 2'd1) && pop));
  end

  // BRAM port mux: config access when granted, otherwise the scan read.
  always_comb begin
    en_bram_o   = cfg_gnt || scan_gnt;
    we_bram_o   = cfg_gnt && cfg_we_i;
    addr_bram_o = cfg_gnt ? cfg_addr_i : next_addr_q;
    din_bram_o  = cfg_gnt ? cfg_din_i : '0;
  end

  assign cfg_gnt_o     = cfg_gnt;
  assign cfg_rvalid_o  = cfg_rvalid_q;
  assign cfg_rdata_o   = cfg_rvalid_q ? dout_bram_i : '0;
  assign scan_ready_o  = (state_q == IDLE);
  assign scan_done_o   = scan_done_q;
  assign entry_valid_o = (count_q != 2'd0);
  assign entry_data_o  = head_data_q;
  assign entry_idx_o   = head_idx_q;

  // Scan sequencer: walks next_addr from first to last, then drains the buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      last_q      <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (scan_start_i) begin
            next_addr_q <= scan_first_i;
            last_q      <= scan_last_i;
            if (scan_first_i > scan_last_i) begin
              scan_done_q <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (aborting) begin
            state_q <= IDLE;
          end else if (scan_gnt) begin
            next_addr_q <= next_addr_q + AW'(1);
            if (next_addr_q == last_q) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (aborting) begin
            state_q <= IDLE;
          end else if (drain_empty) begin
            state_q     <= IDLE;
            scan_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Round-robin pointer, read-return tracking for both requesters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_scan_q      <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      cfg_rvalid_q   <= 1'b0;
    end else begin
      if (cfg_req_i && scan_elig) begin
        rr_scan_q <= cfg_gnt;
      end
      inflight_q     <= scan_gnt;
      inflight_idx_q <= next_addr_q;
      cfg_rvalid_q   <= cfg_gnt && !cfg_we_i;
    end
  end

  // 2-entry buffer; head register drives the entry stream directly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_idx_q  <= '0;
      tail_data_q <= '0;
      tail_idx_q  <= '0;
    end else if (aborting) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_data_q <= dout_bram_i;
            head_idx_q  <= inflight_idx_q;
          end else begin
            tail_data_q <= dout_bram_i;
            tail_idx_q  <= inflight_idx_q;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_data_q <= tail_data_q;
          head_idx_q  <= tail_idx_q;
          count_q     <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_data_q <= dout_bram_i;
            head_idx_q  <= inflight_idx_q;
          end else begin
            head_data_q <= tail_data_q;
            head_idx_q  <= tail_idx_q;
            tail_data_q <= dout_bram_i;
            tail_idx_q  <= inflight_idx_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_iopmp_entry_fetch_arbiter.sv
// Bench for rv_iopmp_entry_fetch_arbiter: BRAM model, shadow copy of entry
// contents, and a scoreboard of expected entries checked as they are popped.

module tb_rv_iopmp_entry_fetch_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 128;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cfg_req_i, cfg_we_i;
  logic [AW-1:0] cfg_addr_i;
  logic [DW-1:0] cfg_din_i;
  logic          cfg_gnt_o, cfg_rvalid_o;
  logic [DW-1:0] cfg_rdata_o;
  logic          scan_start_i, scan_abort_i, scan_ready_o;
  logic [AW-1:0] scan_first_i, scan_last_i;
  logic          entry_valid_o, entry_ready_i, scan_done_o;
  logic [DW-1:0] entry_data_o;
  logic [AW-1:0] entry_idx_o;
  logic          we_bram_o, en_bram_o;
  logic [AW-1:0] addr_bram_o;
  logic [DW-1:0] din_bram_o;
  logic [DW-1:0] dout_bram = '0;

  always #5 clk = ~clk;

  rv_iopmp_entry_fetch_arbiter #(.NUMBER_ENTRIES(N), .BRAM_DWIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_din_i(cfg_din_i), .cfg_gnt_o(cfg_gnt_o), .cfg_rvalid_o(cfg_rvalid_o),
    .cfg_rdata_o(cfg_rdata_o),
    .scan_start_i(scan_start_i), .scan_first_i(scan_first_i),
    .scan_last_i(scan_last_i), .scan_abort_i(scan_abort_i),
    .scan_ready_o(scan_ready_o),
    .entry_valid_o(entry_valid_o), .entry_ready_i(entry_ready_i),
    .entry_data_o(entry_data_o), .entry_idx_o(entry_idx_o),
    .scan_done_o(scan_done_o),
    .we_bram_o(we_bram_o), .en_bram_o(en_bram_o), .addr_bram_o(addr_bram_o),
    .din_bram_o(din_bram_o), .dout_bram_i(dout_bram)
  );

  // single-port BRAM model, 1-cycle read latency
  logic [DW-1:0] bram   [N];
  logic [DW-1:0] shadow [N];
  always @(posedge clk) begin
    if (en_bram_o) begin
      if (we_bram_o) bram[addr_bram_o] <= din_bram_o;
      dout_bram <= bram[addr_bram_o];
    end
  end

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } ent_t;

  ent_t exp_q[$];
  int   deliver_cyc[$];
  int   scan_iss_cyc[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   issued  = 0;
  int   pops    = 0;
  int   max_out = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // output monitor: scoreboard pops, config read data, occupancy, done pulses
  always @(negedge clk) begin
    if (!rst_i) begin
      if (issued - pops > max_out) max_out = issued - pops;
      if (cfg_rvalid_o) chkw("cfg rdata", cfg_rdata_o, rd_pend ? shadow[rd_addr] : '0);
      rd_pend = cfg_gnt_o && !cfg_we_i;
      rd_addr = cfg_addr_i;
      if (en_bram_o && !cfg_gnt_o) begin
        issued++;
        scan_iss_cyc.push_back(cyc);
      end
      if (entry_valid_o && entry_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected entry", 1'b1, 1'b0);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chkw("entry idx", DW'(entry_idx_o), DW'(e.idx));
          chkw("entry data", entry_data_o, e.data);
        end
        pops++;
        deliver_cyc.push_back(cyc);
      end
      if (scan_done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ent_t e;
      e.idx  = AW'(i);
      e.data = shadow[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic start_scan(input int first, input int last, output int t0);
    scan_start_i = 1'b1;
    scan_first_i = AW'(first);
    scan_last_i  = AW'(last);
    t0 = cyc;
    push_range(first, last);
    step();
    scan_start_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int bound, input string tag);
    int k;
    k = 0;
    while (done_cnt == d0 && k < bound) begin
      step();
      k++;
    end
    chk({tag, " done within bound"}, done_cnt != d0, 1'b1);
  endtask

  task automatic cfg_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_req_i  = 1'b1;
    cfg_we_i   = we;
    cfg_addr_i = a;
    cfg_din_i  = d;
    #1;
    chk("idle cfg gnt same cycle", cfg_gnt_o, 1'b1);
    chk("idle cfg en_bram", en_bram_o, 1'b1);
    chk("idle cfg we_bram", we_bram_o, we);
    if (we) shadow[a] = d;
    step();
    cfg_req_i = 1'b0;
    chk("cfg rvalid after access", cfg_rvalid_o, !we);
    if (!we) chkw("cfg read data", cfg_rdata_o, shadow[a]);
  endtask

  initial begin
    int t0;
    int d0;
    int k;
    logic [DW-1:0] a5;
    for (int i = 0; i < int'(N); i++) begin
      bram[i]   = {4{32'hC0DE_0000 + 32'(i)}};
      shadow[i] = {4{32'hC0DE_0000 + 32'(i)}};
    end
    rst_i = 1'b1;
    cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_din_i = '0;
    scan_start_i = 1'b0; scan_first_i = '0; scan_last_i = '0;
    scan_abort_i = 1'b0; entry_ready_i = 1'b1;
    #12;
    // reset values
    chk("rst scan_ready", scan_ready_o, 1'b1);
    chk("rst entry_valid", entry_valid_o, 1'b0);
    chk("rst scan_done", scan_done_o, 1'b0);
    chk("rst cfg_rvalid", cfg_rvalid_o, 1'b0);
    chk("rst en_bram", en_bram_o, 1'b0);
    chkw("rst entry_data", entry_data_o, '0);
    step();
    rst_i = 1'b0;
    step();

    // idle config write then read
    a5 = {16{8'hA5}};
    cfg_op(1'b1, 3'd3, a5);
    cfg_op(1'b0, 3'd3, a5);
    step();

    // scan 2..5 with ready held: entries on cycles 3..6, done on cycle 7
    deliver_cyc.delete();
    d0 = done_cnt;
    start_scan(2, 5, t0);
    wait_done(d0, 40, "scan2-5");
    chki("scan2-5 entries", deliver_cyc.size(), 4);
    for (int i = 0; i < deliver_cyc.size() && i < 4; i++)
      chki("scan2-5 entry cycle", deliver_cyc[i] - t0, 3 + i);
    chki("scan2-5 done cycle", done_cyc - t0, 7);
    chki("scan2-5 scoreboard empty", exp_q.size(), 0);
    step();

    // scan 0..7 with toggling ready
    deliver_cyc.delete();
    max_out = 0;
    d0 = done_cnt;
    start_scan(0, 7, t0);
    k = 0;
    while (done_cnt == d0 && k < 80) begin
      entry_ready_i = ~entry_ready_i;
      step();
      k++;
    end
    entry_ready_i = 1'b1;
    chk("toggle done within bound", done_cnt != d0, 1'b1);
    chki("toggle entries", deliver_cyc.size(), 8);
    chki("toggle scoreboard empty", exp_q.size(), 0);
    chk("toggle buffered <= 2", max_out <= 2, 1'b1);
    step();

    // scan 0..7 under continuous config reads: grants alternate
    deliver_cyc.delete();
    scan_iss_cyc.delete();
    d0 = done_cnt;
    cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = 3'd3;
    start_scan(0, 7, t0);
    wait_done(d0, 80, "contend");
    cfg_req_i = 1'b0;
    chki("contend scan reads", scan_iss_cyc.size(), 8);
    for (int i = 1; i < scan_iss_cyc.size(); i++)
      chki("contend read spacing", scan_iss_cyc[i] - scan_iss_cyc[i-1], 2);
    chki("contend entries", deliver_cyc.size(), 8);
    chki("contend scoreboard empty", exp_q.size(), 0);
    step();

    // empty range 5..2
    d0 = done_cnt;
    scan_start_i = 1'b1; scan_first_i = 3'd5; scan_last_i = 3'd2;
    #1;
    chk("empty en_bram cyc0", en_bram_o, 1'b0);
    step();
    scan_start_i = 1'b0;
    #1;
    chk("empty done pulse cyc1", scan_done_o, 1'b1);
    chk("empty scan_ready cyc1", scan_ready_o, 1'b1);
    chk("empty en_bram cyc1", en_bram_o, 1'b0);
    step();
    chk("empty done one cycle", scan_done_o, 1'b0);
    chki("empty done count", done_cnt - d0, 1);

    // abort after two entries delivered
    d0 = done_cnt;
    k = pops;
    start_scan(0, 7, t0);
    t0 = 0;
    while (pops - k < 2 && t0 < 40) begin
      step();
      t0++;
    end
    entry_ready_i = 1'b0;
    scan_abort_i  = 1'b1;
    step();
    scan_abort_i  = 1'b0;
    chk("abort entry_valid next", entry_valid_o, 1'b0);
    chk("abort scan_ready next", scan_ready_o, 1'b1);
    chki("abort delivered", pops - k, 2);
    chki("abort undelivered", exp_q.size(), 6);
    exp_q.delete();
    entry_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chki("abort no done", done_cnt, d0);
    chk("abort entry_valid later", entry_valid_o, 1'b0);

    // reset in the middle of a scan
    start_scan(0, 7, t0);
    step(); step(); step();
    #2;
    rst_i = 1'b1;
    #1;
    chk("async rst entry_valid", entry_valid_o, 1'b0);
    chk("async rst scan_ready", scan_ready_o, 1'b1);
    chk("async rst en_bram", en_bram_o, 1'b0);
    chkw("async rst entry_data", entry_data_o, '0);
    chkw("async rst entry_idx", DW'(entry_idx_o), '0);
    exp_q.delete();
    step();
    rst_i = 1'b0;
    step(); step();
    chk("post rst entry_valid", entry_valid_o, 1'b0);
    chk("post rst scan_done", scan_done_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
